// File: rtl/mem_resp_stage.sv
// Memory-response pipeline stage between EX and WB: waits for the data-memory
// response, extracts sub-word loads, buffers under WB stall and discards stale responses after flush.
module mem_resp_stage #(
  parameter int PC_W        = 32,
  parameter int RF_AW       = 5,
  parameter int MAX_DISCARD = 3,
  parameter int DISC_W      = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             es_to_ms_valid,
  output logic             ms_allowin,
  input  logic             es_req,
  input  logic [2:0]       es_ld_op,
  input  logic [1:0]       es_addr_lo,
  input  logic [31:0]      es_rt_value,
  input  logic             es_gr_we,
  input  logic [RF_AW-1:0] es_dest,
  input  logic [31:0]      es_exe_result,
  input  logic [PC_W-1:0]  es_pc,
  input  logic             data_ok,
  input  logic [31:0]      data_rdata,
  output logic             ms_discard_full,
  input  logic             ws_allowin,
  output logic             ms_to_ws_valid,
  output logic             ms_gr_we,
  output logic [RF_AW-1:0] ms_dest,
  output logic [31:0]      ms_final_result,
  output logic [PC_W-1:0]  ms_pc,
  output logic             ms_fwd_valid,
  output logic             ms_fwd_blk,
  output logic [RF_AW-1:0] ms_fwd_dest,
  output logic [31:0]      ms_fwd_data
);

  localparam logic [2:0] LD_LW   = 3'd0;
  localparam logic [2:0] LD_LB   = 3'd1;
  localparam logic [2:0] LD_LBU  = 3'd2;
  localparam logic [2:0] LD_LH   = 3'd3;
  localparam logic [2:0] LD_LHU  = 3'd4;
  localparam logic [2:0] LD_LWL  = 3'd5;
  localparam logic [2:0] LD_LWR  = 3'd6;
  localparam logic [2:0] LD_NONE = 3'd7;

  logic              ms_valid;
  logic              got;
  logic [31:0]       rbuf;
  logic [DISC_W-1:0] disc_cnt;

  logic              req;
  logic [2:0]        ld_op;
  logic [1:0]        addr_lo;
  logic [31:0]       rt_value;
  logic              gr_we;
  logic [RF_AW-1:0]  dest;
  logic [31:0]       exe_result;
  logic [PC_W-1:0]   pc;

  logic              live_ok;
  logic              ms_ready_go;
  logic              accept;
  logic              capture;
  logic              disc_inc;
  logic              disc_dec;
  logic [31:0]       rd;
  logic [31:0]       ld_result;

  // Little-endian sub-word extraction and unaligned-word merge with old rt.
  function automatic logic [31:0] load_extract(input logic [2:0]  op,
                                               input logic [1:0]  a,
                                               input logic [31:0] rdat,
                                               input logic [31:0] rt);
    logic [7:0]  ub;
    logic [15:0] uh;
    logic [31:0] res;
    ub  = rdat[{a, 3'b000} +: 8];
    uh  = a[1] ? rdat[31:16] : rdat[15:0];
    res = rdat;
    case (op)
      LD_LB:  res = {{24{ub[7]}}, ub};
      LD_LBU: res = {24'h0, ub};
      LD_LH:  res = {{16{uh[15]}}, uh};
      LD_LHU: res = {16'h0, uh};
      LD_LWL: begin
        case (a)
          2'd0:    res = {rdat[7:0], rt[23:0]};
          2'd1:    res = {rdat[15:0], rt[15:0]};
          2'd2:    res = {rdat[23:0], rt[7:0]};
          default: res = rdat;
        endcase
      end
      LD_LWR: begin
        case (a)
          2'd1:    res = {rt[31:24], rdat[31:8]};
          2'd2:    res = {rt[31:16], rdat[31:16]};
          2'd3:    res = {rt[31:8], rdat[31:24]};
          default: res = rdat;
        endcase
      end
      default: res = rdat;
    endcase
    return res;
  endfunction

  assign live_ok     = data_ok && (disc_cnt == '0);
  assign ms_ready_go = !req || got || live_ok;
  assign ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);
  assign accept      = ms_allowin && es_to_ms_valid && !flush;
  assign capture     = ms_valid && req && !got && live_ok;
  // A killed entry still owes a response unless it arrives in the flush cycle itself.
  assign disc_inc    = flush && ms_valid && req && !got && !live_ok;
  assign disc_dec    = data_ok && (disc_cnt != '0);

  assign rd        = got ? rbuf : data_rdata;
  assign ld_result = load_extract(ld_op, addr_lo, rd, rt_value);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid <= 1'b0;
    end else if (flush) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req        <= 1'b0;
      ld_op      <= LD_NONE;
      addr_lo    <= 2'd0;
      rt_value   <= 32'h0;
      gr_we      <= 1'b0;
      dest       <= '0;
      exe_result <= 32'h0;
      pc         <= '0;
    end else if (accept) begin
      req        <= es_req;
      ld_op      <= es_ld_op;
      addr_lo    <= es_addr_lo;
      rt_value   <= es_rt_value;
      gr_we      <= es_gr_we;
      dest       <= es_dest;
      exe_result <= es_exe_result;
      pc         <= es_pc;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      got  <= 1'b0;
      rbuf <= 32'h0;
    end else if (accept) begin
      got <= 1'b0;
    end else if (capture) begin
      got  <= 1'b1;
      rbuf <= data_rdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      disc_cnt <= '0;
    end else if (disc_inc && !disc_dec) begin
      disc_cnt <= disc_cnt + 1'b1;
    end else if (disc_dec && !disc_inc) begin
      disc_cnt <= disc_cnt - 1'b1;
    end
  end

  assign ms_discard_full = (disc_cnt == DISC_W'(MAX_DISCARD));
  assign ms_to_ws_valid  = ms_valid && ms_ready_go;
  assign ms_gr_we        = gr_we;
  assign ms_dest         = dest;
  assign ms_pc           = pc;
  assign ms_final_result = (ld_op != LD_NONE) ? ld_result : exe_result;

  assign ms_fwd_valid = ms_valid && gr_we;
  assign ms_fwd_blk   = ms_valid && gr_we && (ld_op != LD_NONE) && !ms_ready_go;
  assign ms_fwd_dest  = dest;
  assign ms_fwd_data  = ms_final_result;

endmodule

// File: tb/tb_mem_resp_stage.sv
// Directed bench for mem_resp_stage: pass-through, sub-word loads, WB stall,
// flush discard and discard-counter saturation, with hand-computed expectations.
module tb_mem_resp_stage;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic        es_req;
  logic [2:0]  es_ld_op;
  logic [1:0]  es_addr_lo;
  logic [31:0] es_rt_value;
  logic        es_gr_we;
  logic [4:0]  es_dest;
  logic [31:0] es_exe_result;
  logic [31:0] es_pc;
  logic        data_ok;
  logic [31:0] data_rdata;
  logic        ms_discard_full;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_final_result;
  logic [31:0] ms_pc;
  logic        ms_fwd_valid;
  logic        ms_fwd_blk;
  logic [4:0]  ms_fwd_dest;
  logic [31:0] ms_fwd_data;

  int passed = 0;
  int total  = 0;

  mem_resp_stage #(.PC_W(32), .RF_AW(5), .MAX_DISCARD(3), .DISC_W(2)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_req(es_req), .es_ld_op(es_ld_op), .es_addr_lo(es_addr_lo),
    .es_rt_value(es_rt_value), .es_gr_we(es_gr_we), .es_dest(es_dest),
    .es_exe_result(es_exe_result), .es_pc(es_pc),
    .data_ok(data_ok), .data_rdata(data_rdata),
    .ms_discard_full(ms_discard_full), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest),
    .ms_final_result(ms_final_result), .ms_pc(ms_pc),
    .ms_fwd_valid(ms_fwd_valid), .ms_fwd_blk(ms_fwd_blk),
    .ms_fwd_dest(ms_fwd_dest), .ms_fwd_data(ms_fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] a, input logic [31:0] rt,
                       input logic rq, input logic [31:0] exe, input logic [4:0] dst,
                       input logic [31:0] pcv);
    es_to_ms_valid = 1'b1;
    es_ld_op       = op;
    es_addr_lo     = a;
    es_rt_value    = rt;
    es_req         = rq;
    es_exe_result  = exe;
    es_dest        = dst;
    es_gr_we       = 1'b1;
    es_pc          = pcv;
  endtask

  // Load whose response arrives in its first resident cycle.
  task automatic ld_chk(input string tag, input logic [2:0] op, input logic [1:0] a,
                        input logic [31:0] rt, input logic [31:0] rdat, input logic [31:0] exp);
    issue(op, a, rt, 1'b1, 32'hCAFE_0000, 5'd9, 32'h0000_0200);
    tick();
    es_to_ms_valid = 1'b0;
    data_ok        = 1'b1;
    data_rdata     = rdat;
    #1;
    chk({tag, "_vld"}, 32'(ms_to_ws_valid), 32'd1);
    chk({tag, "_res"}, ms_final_result, exp);
    tick();
    data_ok = 1'b0;
    #1;
    chk({tag, "_gone"}, 32'(ms_to_ws_valid), 32'd0);
  endtask

  task automatic flush_pending();
    issue(3'd0, 2'd0, 32'h0, 1'b1, 32'h0, 5'd4, 32'h0000_0300);
    tick();
    es_to_ms_valid = 1'b0;
    flush          = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; es_to_ms_valid = 1'b0; es_req = 1'b0;
    es_ld_op = 3'd7; es_addr_lo = 2'd0; es_rt_value = 32'h0; es_gr_we = 1'b0;
    es_dest = 5'd0; es_exe_result = 32'h0; es_pc = 32'h0;
    data_ok = 1'b0; data_rdata = 32'h0; ws_allowin = 1'b1;

    #12;
    chk("rst_to_ws", 32'(ms_to_ws_valid), 32'd0);
    chk("rst_fwd_valid", 32'(ms_fwd_valid), 32'd0);
    chk("rst_fwd_blk", 32'(ms_fwd_blk), 32'd0);
    chk("rst_disc_full", 32'(ms_discard_full), 32'd0);
    chk("rst_allowin", 32'(ms_allowin), 32'd1);
    resetn = 1'b1;

    // ALU pass-through
    tick();
    issue(3'd7, 2'd0, 32'h0, 1'b0, 32'h1234_5678, 5'd7, 32'h0000_0100);
    #1;
    chk("alu_allowin", 32'(ms_allowin), 32'd1);
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    chk("alu_vld", 32'(ms_to_ws_valid), 32'd1);
    chk("alu_res", ms_final_result, 32'h1234_5678);
    chk("alu_dest", 32'(ms_dest), 32'd7);
    chk("alu_pc", ms_pc, 32'h0000_0100);
    chk("alu_fwd_valid", 32'(ms_fwd_valid), 32'd1);
    chk("alu_fwd_blk", 32'(ms_fwd_blk), 32'd0);
    chk("alu_fwd_data", ms_fwd_data, 32'h1234_5678);
    tick();
    chk("alu_gone", 32'(ms_to_ws_valid), 32'd0);

    // Sub-word loads and merges
    ld_chk("lb3",  3'd1, 2'd3, 32'h0, 32'h80FF_7F01, 32'hFFFF_FF80);
    ld_chk("lb0",  3'd1, 2'd0, 32'h0, 32'h80FF_7F01, 32'h0000_0001);
    ld_chk("lbu1", 3'd2, 2'd1, 32'h0, 32'h80FF_7F01, 32'h0000_007F);
    ld_chk("lh2",  3'd3, 2'd2, 32'h0, 32'h80FF_7F01, 32'hFFFF_80FF);
    ld_chk("lhu0", 3'd4, 2'd0, 32'h0, 32'h80FF_7F01, 32'h0000_7F01);
    ld_chk("lw",   3'd0, 2'd0, 32'h0, 32'h80FF_7F01, 32'h80FF_7F01);
    ld_chk("lwl1", 3'd5, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'h3344_CCDD);
    ld_chk("lwl0", 3'd5, 2'd0, 32'hAABB_CCDD, 32'h1122_3344, 32'h44BB_CCDD);
    ld_chk("lwl3", 3'd5, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 32'h1122_3344);
    ld_chk("lwr2", 3'd6, 2'd2, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_1122);
    ld_chk("lwr3", 3'd6, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_CC11);
    ld_chk("store", 3'd7, 2'd0, 32'h0, 32'h5555_5555, 32'hCAFE_0000);

    // Delayed response under WB stall
    issue(3'd0, 2'd0, 32'h0, 1'b1, 32'h0, 5'd3, 32'h0000_0400);
    tick();
    es_to_ms_valid = 1'b0;
    ws_allowin     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("dly_blk", 32'(ms_fwd_blk), 32'd1);
      chk("dly_novld", 32'(ms_to_ws_valid), 32'd0);
      tick();
    end
    data_ok    = 1'b1;
    data_rdata = 32'hDEAD_BEEF;
    #1;
    chk("dly_ok_vld", 32'(ms_to_ws_valid), 32'd1);
    chk("dly_ok_blk", 32'(ms_fwd_blk), 32'd0);
    chk("dly_ok_res", ms_final_result, 32'hDEAD_BEEF);
    tick();
    data_ok    = 1'b0;
    data_rdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("stall_res", ms_final_result, 32'hDEAD_BEEF);
      chk("stall_allowin", 32'(ms_allowin), 32'd0);
      tick();
    end
    ws_allowin = 1'b1;
    #1;
    chk("rel_res", ms_final_result, 32'hDEAD_BEEF);
    chk("rel_allowin", 32'(ms_allowin), 32'd1);
    tick();
    chk("rel_gone", 32'(ms_to_ws_valid), 32'd0);

    // Flush while waiting, stale response dropped
    issue(3'd0, 2'd0, 32'h0, 1'b1, 32'h0, 5'd5, 32'h0000_0500);
    tick();
    es_to_ms_valid = 1'b0;
    flush          = 1'b1;
    #1;
    chk("fl_blk", 32'(ms_fwd_blk), 32'd1);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_novld", 32'(ms_fwd_valid), 32'd0);
    chk("fl_allowin", 32'(ms_allowin), 32'd1);
    issue(3'd7, 2'd0, 32'h0, 1'b0, 32'h0000_0055, 5'd6, 32'h0000_0504);
    tick();
    es_to_ms_valid = 1'b0;
    data_ok        = 1'b1;
    data_rdata     = 32'hBAD0_BAD0;
    #1;
    chk("fl_alu_vld", 32'(ms_to_ws_valid), 32'd1);
    chk("fl_alu_res", ms_final_result, 32'h0000_0055);
    tick();
    data_ok = 1'b0;
    issue(3'd0, 2'd0, 32'h0, 1'b1, 32'h0, 5'd8, 32'h0000_0508);
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    chk("fl_lw_blk", 32'(ms_fwd_blk), 32'd1);
    data_ok    = 1'b1;
    data_rdata = 32'h0600_D600;
    #1;
    chk("fl_lw_vld", 32'(ms_to_ws_valid), 32'd1);
    chk("fl_lw_res", ms_final_result, 32'h0600_D600);
    tick();
    data_ok = 1'b0;

    // Response arriving in the flush cycle is consumed, nothing to discard
    issue(3'd0, 2'd0, 32'h0, 1'b1, 32'h0, 5'd8, 32'h0000_0600);
    tick();
    es_to_ms_valid = 1'b0;
    flush          = 1'b1;
    data_ok        = 1'b1;
    data_rdata     = 32'h7777_7777;
    tick();
    flush   = 1'b0;
    data_ok = 1'b0;
    ld_chk("fl_same", 3'd0, 2'd0, 32'h0, 32'h1357_9BDF, 32'h1357_9BDF);

    // Discard saturation
    for (int i = 0; i < 3; i++) begin
      flush_pending();
      #1;
      chk("sat_full", 32'(ms_discard_full), (i == 2) ? 32'd1 : 32'd0);
    end
    data_ok = 1'b1;
    tick();
    data_ok = 1'b0;
    #1;
    chk("sat_dec", 32'(ms_discard_full), 32'd0);
    // decrement and increment in the same cycle leave the count at 2
    issue(3'd0, 2'd0, 32'h0, 1'b1, 32'h0, 5'd4, 32'h0000_0700);
    tick();
    es_to_ms_valid = 1'b0;
    flush          = 1'b1;
    data_ok        = 1'b1;
    tick();
    flush   = 1'b0;
    data_ok = 1'b0;
    #1;
    chk("sat_both", 32'(ms_discard_full), 32'd0);
    flush_pending();
    #1;
    chk("sat_full2", 32'(ms_discard_full), 32'd1);
    data_ok = 1'b1;
    tick();
    tick();
    tick();
    data_ok = 1'b0;
    #1;
    chk("sat_drained", 32'(ms_discard_full), 32'd0);
    ld_chk("sat_lw", 3'd0, 2'd0, 32'h0, 32'h2468_ACE0, 32'h2468_ACE0);

    // Reset clears discard state and a waiting entry
    for (int i = 0; i < 3; i++) flush_pending();
    #1;
    chk("rst2_full_pre", 32'(ms_discard_full), 32'd1);
    resetn = 1'b0;
    #1;
    chk("rst2_full", 32'(ms_discard_full), 32'd0);
    resetn = 1'b1;
    tick();
    issue(3'd0, 2'd0, 32'h0, 1'b1, 32'h0, 5'd2, 32'h0000_0800);
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    chk("rst3_blk_pre", 32'(ms_fwd_blk), 32'd1);
    resetn = 1'b0;
    #1;
    chk("rst3_to_ws", 32'(ms_to_ws_valid), 32'd0);
    chk("rst3_blk", 32'(ms_fwd_blk), 32'd0);
    chk("rst3_allowin", 32'(ms_allowin), 32'd1);
    resetn = 1'b1;
    tick();
    ld_chk("post_rst", 3'd0, 2'd0, 32'h0, 32'h0BAD_F00D, 32'h0BAD_F00D);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
